// File: rtl/motion_update_bcast_arbiter.sv
// Motion-update epoch sequencer and round-robin broadcast bus arbiter for the position-cache array.
// Latency: granted beat appears on out_data one cycle after transfer; first beat >= 2 cycles after in_start.
// Backpressure: combinational one-hot out_req_ready; an ungranted requester holds its beat until served.
// Optional feature macro: MU_BCAST_BEAT_COUNT_EN adds out_beat_count (saturating per-epoch beat counter).
module motion_update_bcast_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int CELL_ID_WIDTH = 4,
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 3,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_start,
  input  logic [NUM_REQ-1:0]                   in_req_valid,
  input  logic [NUM_REQ*3*DATA_WIDTH-1:0]      in_req_data,
  input  logic [NUM_REQ*3*CELL_ID_WIDTH-1:0]   in_req_dst_cell,
  input  logic [NUM_REQ-1:0]                   in_req_done,
  output logic [NUM_REQ-1:0]                   out_req_ready,
  output logic                                 out_motion_update_enable,
  output logic [3*DATA_WIDTH-1:0]              out_data,
  output logic [3*CELL_ID_WIDTH-1:0]           out_data_dst_cell,
  output logic                                 out_data_valid,
  output logic                                 out_busy,
`ifdef MU_BCAST_BEAT_COUNT_EN
  output logic [COUNT_WIDTH-1:0]               out_beat_count,
`endif
  output logic                                 out_done
);

  localparam int BEAT_W = 3 * DATA_WIDTH;
  localparam int CELL_W = 3 * CELL_ID_WIDTH;
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [PTR_W-1:0]  RR_RESET    = PTR_W'(NUM_REQ - 1);
  localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BCAST  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              state_q,     state_d;
  logic                enable_q,    enable_d;
  logic [BEAT_W-1:0]   data_q,      data_d;
  logic [CELL_W-1:0]   cell_q,      cell_d;
  logic                dvld_q,      dvld_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic [NUM_REQ-1:0]  done_flag_q, done_flag_d;
  logic [PTR_W-1:0]    rr_ptr_q,    rr_ptr_d;
  logic [SCNT_W-1:0]   scnt_q,      scnt_d;
`ifdef MU_BCAST_BEAT_COUNT_EN
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
`endif

  logic [NUM_REQ-1:0]  grant;
  logic [PTR_W-1:0]    grant_idx;
  logic                grant_vld;
  logic [PTR_W-1:0]    cand;

  // Round-robin search starting one past the last granted requester; only live during the broadcast phase.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    if (state_q == ST_BCAST) begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
        if (!grant_vld && in_req_valid[cand]) begin
          grant_vld   = 1'b1;
          grant_idx   = cand;
          grant[cand] = 1'b1;
        end
      end
    end
  end

  // Epoch sequencing: next state, next registered outputs, sticky done flags and pointer update.
  always_comb begin
    state_d     = state_q;
    enable_d    = enable_q;
    data_d      = '0;
    cell_d      = '0;
    dvld_d      = 1'b0;
    done_d      = 1'b0;
    done_flag_d = done_flag_q;
    rr_ptr_d    = rr_ptr_q;
    scnt_d      = scnt_q;
`ifdef MU_BCAST_BEAT_COUNT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_start) begin
          state_d     = ST_BCAST;
          enable_d    = 1'b1;
          done_flag_d = '0;
`ifdef MU_BCAST_BEAT_COUNT_EN
          cnt_d       = '0;
`endif
        end
      end
      ST_BCAST: begin
        done_flag_d = done_flag_q | in_req_done;
        if (grant_vld) begin
          rr_ptr_d = grant_idx;
          data_d   = in_req_data[grant_idx*BEAT_W +: BEAT_W];
          cell_d   = in_req_dst_cell[grant_idx*CELL_W +: CELL_W];
          dvld_d   = 1'b1;
`ifdef MU_BCAST_BEAT_COUNT_EN
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
`endif
        end
        // No valid request means no grant, so the exit cycle never carries a new beat.
        if ((&done_flag_d) && (in_req_valid == '0)) begin
          state_d  = ST_SETTLE;
          enable_d = 1'b0;
          scnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        enable_d = 1'b0;
        if (scnt_q == SETTLE_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        enable_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; synchronous reset abandons any epoch in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      enable_q    <= 1'b0;
      data_q      <= '0;
      cell_q      <= '0;
      dvld_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_flag_q <= '0;
      rr_ptr_q    <= RR_RESET;
      scnt_q      <= '0;
`ifdef MU_BCAST_BEAT_COUNT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      data_q      <= data_d;
      cell_q      <= cell_d;
      dvld_q      <= dvld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      done_flag_q <= done_flag_d;
      rr_ptr_q    <= rr_ptr_d;
      scnt_q      <= scnt_d;
`ifdef MU_BCAST_BEAT_COUNT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign out_req_ready            = grant;
  assign out_motion_update_enable = enable_q;
  assign out_data                 = data_q;
  assign out_data_dst_cell        = cell_q;
  assign out_data_valid           = dvld_q;
  assign out_busy                 = busy_q;
  assign out_done                 = done_q;
`ifdef MU_BCAST_BEAT_COUNT_EN
  assign out_beat_count           = cnt_q;
`endif

endmodule

// File: tb/tb_motion_update_bcast_arbiter.sv
// Directed bench for motion_update_bcast_arbiter: epoch sequencing, round-robin order, reset and start filtering.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Optional beat counter scenario runs only when MU_BCAST_BEAT_COUNT_EN is defined.
module tb_motion_update_bcast_arbiter;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int NR = 4;
  localparam int BW = 3 * DW;
  localparam int XW = 3 * CW;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_start;
  logic [NR-1:0]     in_req_valid;
  logic [NR*BW-1:0]  in_req_data;
  logic [NR*XW-1:0]  in_req_dst_cell;
  logic [NR-1:0]     in_req_done;
  logic [NR-1:0]     out_req_ready;
  logic              out_motion_update_enable;
  logic [BW-1:0]     out_data;
  logic [XW-1:0]     out_data_dst_cell;
  logic              out_data_valid;
  logic              out_busy;
  logic              out_done;
`ifdef MU_BCAST_BEAT_COUNT_EN
  logic [15:0]       out_beat_count;
`endif

  int checks = 0;
  int passed = 0;

  motion_update_bcast_arbiter #(
    .DATA_WIDTH(DW), .CELL_ID_WIDTH(CW), .NUM_REQ(NR), .SETTLE_CYCLES(3), .COUNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_start(in_start),
    .in_req_valid(in_req_valid),
    .in_req_data(in_req_data),
    .in_req_dst_cell(in_req_dst_cell),
    .in_req_done(in_req_done),
    .out_req_ready(out_req_ready),
    .out_motion_update_enable(out_motion_update_enable),
    .out_data(out_data),
    .out_data_dst_cell(out_data_dst_cell),
    .out_data_valid(out_data_valid),
    .out_busy(out_busy),
`ifdef MU_BCAST_BEAT_COUNT_EN
    .out_beat_count(out_beat_count),
`endif
    .out_done(out_done)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] pay(input int i, input int k);
    return {32'(k), 32'(i), 32'hCAFE_0000 + 32'(i * 16 + k)};
  endfunction

  function automatic logic [XW-1:0] dcell(input int i, input int k);
    return {4'(i), 4'(k), 4'hC};
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [BW-1:0] d, input logic [XW-1:0] c);
    in_req_data[i*BW +: BW]     = d;
    in_req_dst_cell[i*XW +: XW] = c;
  endtask

  task automatic do_reset;
    rst = 1'b1; in_start = 1'b0; in_req_valid = '0; in_req_done = '0;
    in_req_data = '0; in_req_dst_cell = '0;
    next_cycle;
    next_cycle;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_start = 1'b0; in_req_done = '0;
    in_req_valid = 4'hF; in_req_data = '0; in_req_dst_cell = '0;
    next_cycle;
    next_cycle;
    @(negedge clk);
    checks++; if (out_motion_update_enable !== 1'b0) $display("FAIL reset_enable: got %b want 0", out_motion_update_enable); else passed++;
    checks++; if (out_req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", out_req_ready); else passed++;
    checks++; if (out_data_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_data_valid); else passed++;
    checks++; if (out_busy !== 1'b0 || out_done !== 1'b0) $display("FAIL reset_busy_done: got %b%b want 00", out_busy, out_done); else passed++;
    checks++; if (out_data !== '0 || out_data_dst_cell !== '0) $display("FAIL reset_data: got %h/%h want 0", out_data, out_data_dst_cell); else passed++;
`ifdef MU_BCAST_BEAT_COUNT_EN
    checks++; if (out_beat_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", out_beat_count); else passed++;
`endif
    next_cycle;
    rst = 1'b0;
    next_cycle;
    @(negedge clk);
    checks++; if (out_req_ready !== 4'b0000 || out_busy !== 1'b0) $display("FAIL idle_ready_with_valid: ready %b busy %b want 0000 0", out_req_ready, out_busy); else passed++;
    in_req_valid = '0;
    next_cycle;
  endtask

  task automatic test_single_requester;
    int n;
    do_reset;
    in_start = 1'b1;
    next_cycle;
    in_start = 1'b0; in_req_done = 4'b1110; in_req_valid = 4'b0001;
    set_req(0, pay(0, 0), dcell(0, 0));
    @(negedge clk);
    checks++; if (out_motion_update_enable !== 1'b1 || out_busy !== 1'b1) $display("FAIL t1_enable_first: en %b busy %b want 1 1", out_motion_update_enable, out_busy); else passed++;
    checks++; if (out_data_valid !== 1'b0) $display("FAIL t1_no_early_beat: got %b want 0", out_data_valid); else passed++;
    checks++; if (out_req_ready !== 4'b0001) $display("FAIL t1_grant0: got %b want 0001", out_req_ready); else passed++;
    for (int k = 1; k <= 3; k++) begin
      next_cycle;
      if (k < 3) set_req(0, pay(0, k), dcell(0, k));
      else begin in_req_valid = '0; in_req_done = 4'b1111; end
      @(negedge clk);
      checks++; if (out_data_valid !== 1'b1 || out_data !== pay(0, k - 1)) $display("FAIL t1_beat%0d: vld %b data %h want 1 %h", k - 1, out_data_valid, out_data, pay(0, k - 1)); else passed++;
      checks++; if (out_data_dst_cell !== dcell(0, k - 1) || out_motion_update_enable !== 1'b1) $display("FAIL t1_cell%0d: cell %h en %b want %h 1", k - 1, out_data_dst_cell, out_motion_update_enable, dcell(0, k - 1)); else passed++;
    end
    next_cycle;
    in_req_done = '0;
    @(negedge clk);
    checks++; if (out_motion_update_enable !== 1'b0 || out_data_valid !== 1'b0 || out_busy !== 1'b1 || out_done !== 1'b0) $display("FAIL t1_settle_entry: en %b vld %b busy %b done %b want 0 0 1 0", out_motion_update_enable, out_data_valid, out_busy, out_done); else passed++;
    n = 0;
    while (out_done !== 1'b1 && n < 10) begin next_cycle; @(negedge clk); n++; end
    checks++; if (n !== 3) $display("FAIL t1_done_latency: got %0d cycles want 3", n); else passed++;
    next_cycle;
    @(negedge clk);
    checks++; if (out_done !== 1'b0 || out_busy !== 1'b0) $display("FAIL t1_done_pulse_width: done %b busy %b want 0 0", out_done, out_busy); else passed++;
  endtask

  task automatic test_back_to_back;
    int sent [NR];
    int n;
    logic [NR-1:0] exp_grant;
    do_reset;
    for (int i = 0; i < NR; i++) sent[i] = 0;
    in_start = 1'b1;
    next_cycle;
    in_start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < NR; i++) begin
        in_req_valid[i] = (sent[i] < 2);
        in_req_done[i]  = (sent[i] >= 2);
        set_req(i, pay(i, sent[i]), dcell(i, sent[i]));
      end
      @(negedge clk);
      exp_grant = (c < 8) ? NR'(1 << (c % 4)) : '0;
      checks++; if (out_req_ready !== exp_grant) $display("FAIL t2_grant_c%0d: got %b want %b", c, out_req_ready, exp_grant); else passed++;
      if (c >= 1 && c <= 8) begin
        checks++; if (out_data_valid !== 1'b1 || out_data !== pay((c - 1) % 4, (c - 1) / 4)) $display("FAIL t2_beat_c%0d: vld %b data %h want 1 %h", c, out_data_valid, out_data, pay((c - 1) % 4, (c - 1) / 4)); else passed++;
      end
      checks++; if (out_motion_update_enable !== (c <= 8)) $display("FAIL t2_enable_c%0d: got %b want %b", c, out_motion_update_enable, (c <= 8)); else passed++;
      for (int i = 0; i < NR; i++) if (out_req_ready[i] && in_req_valid[i]) sent[i]++;
      next_cycle;
    end
    in_req_valid = '0; in_req_done = '0;
    n = 0;
    @(negedge clk);
    while (out_done !== 1'b1 && n < 10) begin next_cycle; @(negedge clk); n++; end
    checks++; if (out_done !== 1'b1) $display("FAIL t2_done: got %b want 1 within 10 cycles", out_done); else passed++;
    next_cycle;
  endtask

  task automatic test_start_ignored;
    int pulses;
    do_reset;
    in_start = 1'b1;
    next_cycle;
    @(negedge clk);
    checks++; if (out_motion_update_enable !== 1'b1) $display("FAIL t3_bcast_enter: got %b want 1", out_motion_update_enable); else passed++;
    next_cycle;
    in_start = 1'b0; in_req_done = 4'b1111;
    @(negedge clk);
    checks++; if (out_motion_update_enable !== 1'b1 || out_busy !== 1'b1) $display("FAIL t3_start_in_bcast: en %b busy %b want 1 1", out_motion_update_enable, out_busy); else passed++;
    next_cycle;
    in_req_done = '0; in_start = 1'b1;
    @(negedge clk);
    checks++; if (out_motion_update_enable !== 1'b0 || out_busy !== 1'b1) $display("FAIL t3_settle_entry: en %b busy %b want 0 1", out_motion_update_enable, out_busy); else passed++;
    next_cycle;
    in_start = 1'b0;
    @(negedge clk);
    checks++; if (out_motion_update_enable !== 1'b0) $display("FAIL t3_start_in_settle: got %b want 0", out_motion_update_enable); else passed++;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_done === 1'b1) pulses++;
      next_cycle;
    end
    checks++; if (pulses !== 1) $display("FAIL t3_done_count: got %0d want 1", pulses); else passed++;
    @(negedge clk);
    checks++; if (out_busy !== 1'b0 || out_motion_update_enable !== 1'b0) $display("FAIL t3_back_idle: busy %b en %b want 0 0", out_busy, out_motion_update_enable); else passed++;
  endtask

  task automatic test_empty_epoch;
    int n;
    do_reset;
    in_start = 1'b1;
    next_cycle;
    in_start = 1'b0; in_req_done = 4'b1111;
    @(negedge clk);
    checks++; if (out_motion_update_enable !== 1'b1 || out_data_valid !== 1'b0) $display("FAIL t4_first_cycle: en %b vld %b want 1 0", out_motion_update_enable, out_data_valid); else passed++;
    next_cycle;
    in_req_done = '0;
    @(negedge clk);
    checks++; if (out_motion_update_enable !== 1'b0 || out_data_valid !== 1'b0) $display("FAIL t4_enable_one_cycle: en %b vld %b want 0 0", out_motion_update_enable, out_data_valid); else passed++;
    n = 0;
    while (out_done !== 1'b1 && n < 10) begin next_cycle; @(negedge clk); n++; end
    checks++; if (n !== 3) $display("FAIL t4_done_latency: got %0d cycles want 3", n); else passed++;
    next_cycle;
  endtask

  task automatic test_reset_mid_epoch;
    int n;
    do_reset;
    in_start = 1'b1;
    next_cycle;
    in_start = 1'b0; in_req_valid = 4'b0010;
    set_req(1, pay(1, 5), dcell(1, 5));
    @(negedge clk);
    checks++; if (out_req_ready !== 4'b0010) $display("FAIL t5_grant1: got %b want 0010", out_req_ready); else passed++;
    rst = 1'b1;
    next_cycle;
    @(negedge clk);
    checks++; if (out_motion_update_enable !== 1'b0 || out_req_ready !== 4'b0000 || out_data_valid !== 1'b0 || out_busy !== 1'b0) $display("FAIL t5_after_rst: en %b rdy %b vld %b busy %b want 0 0000 0 0", out_motion_update_enable, out_req_ready, out_data_valid, out_busy); else passed++;
    rst = 1'b0; in_req_valid = '0;
    next_cycle;
    in_start = 1'b1;
    next_cycle;
    in_start = 1'b0; in_req_done = 4'b1111;
    @(negedge clk);
    checks++; if (out_motion_update_enable !== 1'b1) $display("FAIL t5_restart: got %b want 1", out_motion_update_enable); else passed++;
    next_cycle;
    in_req_done = '0;
    n = 0;
    @(negedge clk);
    while (out_done !== 1'b1 && n < 10) begin next_cycle; @(negedge clk); n++; end
    checks++; if (out_done !== 1'b1) $display("FAIL t5_restart_done: got %b want 1 within 10 cycles", out_done); else passed++;
    next_cycle;
  endtask

`ifdef MU_BCAST_BEAT_COUNT_EN
  task automatic test_beat_count;
    int n;
    do_reset;
    in_start = 1'b1;
    next_cycle;
    in_start = 1'b0; in_req_done = 4'b1011;
    for (int k = 0; k < 7; k++) begin
      in_req_valid = 4'b0100;
      set_req(2, pay(2, k), dcell(2, k));
      next_cycle;
    end
    in_req_valid = '0; in_req_done = 4'b1111;
    next_cycle;
    in_req_done = '0;
    n = 0;
    @(negedge clk);
    while (out_done !== 1'b1 && n < 10) begin next_cycle; @(negedge clk); n++; end
    checks++; if (out_beat_count !== 16'd7) $display("FAIL t6_count_at_done: got %0d want 7", out_beat_count); else passed++;
    next_cycle;
    @(negedge clk);
    checks++; if (out_beat_count !== 16'd7) $display("FAIL t6_count_held: got %0d want 7", out_beat_count); else passed++;
    in_start = 1'b1;
    next_cycle;
    in_start = 1'b0;
    @(negedge clk);
    checks++; if (out_beat_count !== 16'd0) $display("FAIL t6_count_cleared: got %0d want 0", out_beat_count); else passed++;
    next_cycle;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single_requester;
    test_back_to_back;
    test_start_ignored;
    test_empty_epoch;
    test_reset_mid_epoch;
`ifdef MU_BCAST_BEAT_COUNT_EN
    test_beat_count;
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
